packet_serializer: RTL and testbench

- Converts one wide host send request into an AXI4-Stream frame for the Aurora TX interface: one header beat, then NUMBER_PACKET payload beats.
- Sits between the router's send buffer and the Aurora TX user interface.
- Has no backpressure input. Once a frame starts it streams one beat per clock and pulses done_serializer when finished.

---
 rtl/packet_serializer.sv | 123 ++++++++++++
 tb/tb_packet_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// Serializes one wide send request into an Aurora AXI4-Stream frame: header beat, then payload beats.
// Optional SERIALIZER_MSB_FIRST_EN sends the most significant payload chunk first instead of the least.
module packet_serializer #(
   parameter int NUMER_OF_LANE          = 2,
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int SEND_DATA_WIDTH        = 512,
   parameter int RECOGNIZE_HEADER_WIDTH = 8,
   parameter int RECOGNIZE_ROUTER_WIDTH = 8,
   parameter int HOST_PAYLOAD_WIDTH     = 16,
   parameter int NUMBER_PACKET          = 8,
   parameter int ADDR_WIDTH             = 8,
   parameter int NUMBER_OF_TTL          = 15,
   parameter int TTL_WIDTH              = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              send_data_valid,
   input  logic [SEND_DATA_WIDTH-1:0]        v_data_read,
   input  logic [ADDR_WIDTH-1:0]             dst_addr_send,
   input  logic [TTL_WIDTH-1:0]              TTL_send,
   input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_send,
   output logic                              axis_tx_tvalid,
   output logic                              axis_tx_tlast,
   output logic [AURORA_DATA_WIDTH-1:0]      axis_tx_tdata,
   output logic                              done_serializer
);

   localparam int HDR_USED = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH + ADDR_WIDTH
                           + TTL_WIDTH + HOST_PAYLOAD_WIDTH;
   localparam int CNT_W = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUMBER_PACKET - 1);
   localparam logic [RECOGNIZE_HEADER_WIDTH-1:0] MAGIC = RECOGNIZE_HEADER_WIDTH'(8'hA5);
   localparam logic [HOST_PAYLOAD_WIDTH-1:0] LENGTH = HOST_PAYLOAD_WIDTH'(NUMBER_PACKET);
   localparam logic [TTL_WIDTH:0] TTL_MAX = (TTL_WIDTH + 1)'(NUMBER_OF_TTL);

   if ((AURORA_DATA_WIDTH != 32 * NUMER_OF_LANE) ||
       (SEND_DATA_WIDTH != NUMBER_PACKET * AURORA_DATA_WIDTH) ||
       (HDR_USED > AURORA_DATA_WIDTH)) begin : g_bad_config
      $error("packet_serializer: inconsistent width parameters");
   end

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

   state_t                            state;
   logic [SEND_DATA_WIDTH-1:0]        data_q;
   logic [ADDR_WIDTH-1:0]             dst_q;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_q;
   logic [TTL_WIDTH-1:0]              ttl_q;
   logic [CNT_W-1:0]                  beat_cnt;
   logic [TTL_WIDTH-1:0]              ttl_clamped;
   logic [HDR_USED-1:0]               header_fields;
   logic [AURORA_DATA_WIDTH-1:0]      header_word;
   logic [AURORA_DATA_WIDTH-1:0]      payload_chunk;
   logic [SEND_DATA_WIDTH-1:0]        data_next;

   assign ttl_clamped   = ({1'b0, TTL_send} > TTL_MAX) ? TTL_MAX[TTL_WIDTH-1:0] : TTL_send;
   assign header_fields = {MAGIC, router_q, dst_q, ttl_q, LENGTH};
   assign header_word   = AURORA_DATA_WIDTH'(header_fields) << (AURORA_DATA_WIDTH - HDR_USED);

   // The captured payload is shifted one chunk per beat so the outgoing chunk is always at one end.
`ifdef SERIALIZER_MSB_FIRST_EN
   assign payload_chunk = data_q[SEND_DATA_WIDTH-1 -: AURORA_DATA_WIDTH];
   assign data_next     = data_q << AURORA_DATA_WIDTH;
`else
   assign payload_chunk = data_q[AURORA_DATA_WIDTH-1:0];
   assign data_next     = data_q >> AURORA_DATA_WIDTH;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         data_q          <= '0;
         dst_q           <= '0;
         router_q        <= '0;
         ttl_q           <= '0;
         beat_cnt        <= '0;
         axis_tx_tvalid  <= 1'b0;
         axis_tx_tlast   <= 1'b0;
         axis_tx_tdata   <= '0;
         done_serializer <= 1'b0;
      end else begin
         axis_tx_tvalid  <= 1'b0;
         axis_tx_tlast   <= 1'b0;
         axis_tx_tdata   <= '0;
         done_serializer <= 1'b0;
         case (state)
            IDLE: begin
               if (send_data_valid) begin
                  data_q   <= v_data_read;
                  dst_q    <= dst_addr_send;
                  router_q <= router_id_send;
                  ttl_q    <= ttl_clamped - 1'b1;
                  state    <= (TTL_send == '0) ? DONE : HEADER;
               end
            end
            HEADER: begin
               axis_tx_tvalid <= 1'b1;
               axis_tx_tdata  <= header_word;
               beat_cnt       <= '0;
               state          <= PAYLOAD;
            end
            PAYLOAD: begin
               axis_tx_tvalid <= 1'b1;
               axis_tx_tdata  <= payload_chunk;
               data_q         <= data_next;
               if (beat_cnt == CNT_LAST) begin
                  axis_tx_tlast <= 1'b1;
                  beat_cnt      <= '0;
                  state         <= DONE;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            DONE: begin
               done_serializer <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed self-checking bench for packet_serializer: reset, framing, TTL drop/clamp,
// busy-ignore, back-to-back requests and mid-frame reset.
module tb_packet_serializer;

   logic         clk;
   logic         rst_n;
   logic         send_data_valid;
   logic [511:0] v_data_read;
   logic [7:0]   dst_addr_send;
   logic [3:0]   TTL_send;
   logic [7:0]   router_id_send;
   logic         axis_tx_tvalid;
   logic         axis_tx_tlast;
   logic [63:0]  axis_tx_tdata;
   logic         done_serializer;

   int compared;
   int mismatched;
   int done_count;
   logic [511:0] pat_a;
   logic [511:0] pat_b;

   packet_serializer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .send_data_valid (send_data_valid),
      .v_data_read     (v_data_read),
      .dst_addr_send   (dst_addr_send),
      .TTL_send        (TTL_send),
      .router_id_send  (router_id_send),
      .axis_tx_tvalid  (axis_tx_tvalid),
      .axis_tx_tlast   (axis_tx_tlast),
      .axis_tx_tdata   (axis_tx_tdata),
      .done_serializer (done_serializer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " tvalid"}, 64'(axis_tx_tvalid), 64'd0);
      check({tag, " tdata"}, axis_tx_tdata, 64'd0);
      check({tag, " done"}, 64'(done_serializer), 64'd0);
   endtask

   task automatic check_header(input string tag, input logic [63:0] exp);
      check({tag, " hdr tvalid"}, 64'(axis_tx_tvalid), 64'd1);
      check({tag, " hdr tlast"}, 64'(axis_tx_tlast), 64'd0);
      check({tag, " hdr tdata"}, axis_tx_tdata, exp);
   endtask

   // Expects the 8 payload beats (one per step) and then the done pulse.
   task automatic check_payload(input string tag, input logic [511:0] v);
      logic [63:0] chunk;
      for (int k = 0; k < 8; k++) begin
         step();
`ifdef SERIALIZER_MSB_FIRST_EN
         chunk = v[511 - k*64 -: 64];
`else
         chunk = v[k*64 +: 64];
`endif
         check($sformatf("%s beat%0d tvalid", tag, k), 64'(axis_tx_tvalid), 64'd1);
         check($sformatf("%s beat%0d tdata", tag, k), axis_tx_tdata, chunk);
         check($sformatf("%s beat%0d tlast", tag, k), 64'(axis_tx_tlast), (k == 7) ? 64'd1 : 64'd0);
      end
      step();
      check({tag, " done"}, 64'(done_serializer), 64'd1);
      check({tag, " done tvalid"}, 64'(axis_tx_tvalid), 64'd0);
      check({tag, " done tlast"}, 64'(axis_tx_tlast), 64'd0);
   endtask

   task automatic request(input logic [511:0] v, input logic [7:0] dst, input logic [3:0] ttl,
                          input logic [7:0] rid);
      send_data_valid = 1'b1;
      v_data_read     = v;
      dst_addr_send   = dst;
      TTL_send        = ttl;
      router_id_send  = rid;
   endtask

   task automatic scramble_inputs();
      send_data_valid = 1'b0;
      v_data_read     = {8{64'hDEAD_BEEF_CAFE_F00D}};
      dst_addr_send   = 8'hEE;
      TTL_send        = 4'h7;
      router_id_send  = 8'h99;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      for (int k = 0; k < 8; k++) begin
         pat_a[k*64 +: 64] = {8{8'(k)}};
         pat_b[k*64 +: 64] = {8{8'(8'hF0 | 8'(k))}};
      end
      rst_n = 1'b0;
      scramble_inputs();

      // Reset state
      step();
      step();
      check_idle("reset");
      check("reset tlast", 64'(axis_tx_tlast), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("idle%0d tvalid", i), 64'(axis_tx_tvalid), 64'd0);
      end

      // Basic frame; inputs change right after capture
      request(pat_a, 8'h12, 4'd5, 8'h03);
      step();
      scramble_inputs();
      check_idle("basic cyc0");
      step();
      check_header("basic", 64'hA503_1240_0080_0000);
      check_payload("basic", pat_a);
      step();
      check("basic done once", 64'(done_serializer), 64'd0);

      // TTL drop
      request(pat_b, 8'h34, 4'd0, 8'h05);
      step();
      scramble_inputs();
      check_idle("drop cyc0");
      step();
      check("drop done", 64'(done_serializer), 64'd1);
      check("drop tvalid", 64'(axis_tx_tvalid), 64'd0);
      step();
      check_idle("drop after");

      // TTL clamp with busy re-requests on cycles 3 and 5
      request(pat_b, 8'h7E, 4'd15, 8'hC3);
      step();
      scramble_inputs();
      done_count = 0;
      step();
      check_header("clamp", 64'hA5C3_7EE0_0080_0000);
      for (int k = 0; k < 8; k++) begin
         if (k == 0 || k == 2) request(pat_a, 8'h11, 4'd3, 8'h22);
         step();
         scramble_inputs();
         check($sformatf("busy beat%0d tdata", k), axis_tx_tdata,
`ifdef SERIALIZER_MSB_FIRST_EN
               pat_b[511 - k*64 -: 64]);
`else
               pat_b[k*64 +: 64]);
`endif
         check($sformatf("busy beat%0d tlast", k), 64'(axis_tx_tlast), (k == 7) ? 64'd1 : 64'd0);
         if (done_serializer) done_count++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (done_serializer) done_count++;
         check($sformatf("busy tail%0d tvalid", i), 64'(axis_tx_tvalid), 64'd0);
      end
      check("busy done count", 64'(done_count), 64'd1);

      // Back-to-back: second request the cycle after done
      request(pat_a, 8'h20, 4'd2, 8'h10);
      step();
      scramble_inputs();
      step();
      check_header("b2b A", 64'hA510_2010_0080_0000);
      check_payload("b2b A", pat_a);
      request(pat_b, 8'hFF, 4'd1, 8'h01);
      step();
      scramble_inputs();
      check_idle("b2b gap");
      step();
      check_header("b2b B", 64'hA501_FF00_0080_0000);
      check_payload("b2b B", pat_b);

      // Reset mid-frame, then a fresh frame
      step();
      request(pat_a, 8'h33, 4'd4, 8'h44);
      step();
      scramble_inputs();
      step();
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      check_idle("midreset");
      check("midreset tlast", 64'(axis_tx_tlast), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post reset%0d tvalid", i), 64'(axis_tx_tvalid), 64'd0);
         check($sformatf("post reset%0d done", i), 64'(done_serializer), 64'd0);
      end
      request(pat_b, 8'hAA, 4'd9, 8'h55);
      step();
      scramble_inputs();
      step();
      check_header("fresh", 64'hA555_AA80_0080_0000);
      check_payload("fresh", pat_b);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
